rom_port_arbiter: RTL and testbench
===================================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive denied instruction-fetch (IF) cycles before IF is forced to win.
REQ-002 Port: clk  input  1  single system clock, rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: if_req  input  1  IF requester wants a ROM word.
REQ-005 Port: if_addr  input  32  IF byte address.
REQ-006 Port: if_ready  output  1  combinational grant; the IF request is accepted when if_req and if_ready are both high.
REQ-007 Port: if_valid / if_data / if_fault  output  1/32/1  registered IF response.
REQ-008 Port: dm_req, dm_addr, dm_ready, dm_valid, dm_data, dm_fault  same directions and widths as the IF set  data-memory (load) requester.
REQ-009 Port: rom_addr  output  32  address driven to the combinational ROM.
REQ-010 Port: rom_data  input  32  ROM read word.
REQ-011 Port: rom_accessable  input  1  ROM reports that the address is mapped.
REQ-012 Port: fault_clear  input  1  clears the sticky fault status.
REQ-013 Port: fault_sticky / fault_addr / fault_port  output  1/32/1  first-fault capture; fault_port is 0 for IF and 1 for DM.

Function
REQ-014 At most one port is granted per cycle; if_ready and dm_ready are never both high.
REQ-015 Priority: DM wins when both ports request, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
REQ-016 starve_cnt: increments, saturating at STARVE_LIMIT, when if_req=1 and if_ready=0; clears to 0 when IF is granted or if_req=0.
REQ-017 rom_addr equals the granted port's address; it equals 0 when neither port is granted.
REQ-018 Latency: a request accepted in cycle N gives <port>_valid=1 in cycle N+1 for exactly one cycle, with <port>_data registered from rom_data in cycle N.
REQ-019 The non-granted port's valid is 0 in cycle N+1.
REQ-020 Fault: the response has fault=1 and data=0x00000000 when the address bits [1:0] != 0 or rom_accessable=0 at accept.
REQ-021 A misaligned address is faulted regardless of rom_accessable.
REQ-022 Requesters hold req and addr stable until ready; the arbiter does not queue requests and keeps no outstanding-request state beyond the response register.
REQ-023 Back-to-back accepts on the same port in consecutive cycles are legal; valid stays high continuously.
REQ-024 Fault capture: when fault_sticky=0 and a faulting accept occurs, fault_sticky is set to 1 next cycle, and fault_addr and fault_port are loaded.
REQ-025 Later faults while fault_sticky=1 do not modify fault_addr or fault_port.
REQ-026 When fault_clear and a new faulting accept occur in the same cycle, the new fault is captured and fault_sticky stays at 1.
REQ-027 fault_clear alone sets fault_sticky=0; fault_addr and fault_port hold their last values.

Reset
REQ-028 On reset=1 at a clock edge, all outputs are 0 in the next cycle: valid, data, fault, fault_sticky, fault_addr and fault_port.
REQ-029 On reset, starve_cnt is set to 0.
REQ-030 While reset=1, if_ready=0, dm_ready=0 and rom_addr=0.
REQ-031 Reset asserted in the cycle after an accept suppresses that response: valid is 0.

Structure
REQ-032 The shared include header holds ROM_BOOT_BASE=0x00000000, ROM_PROG_BASE=0x00400000, PORT_IF=1'b0 and PORT_DM=1'b1.
REQ-033 The grant/priority logic is a combinational sub-module, rom_grant_pick, with inputs if_req, dm_req and starve_hit, and outputs gnt_if and gnt_dm.
REQ-034 The registers (response, starve_cnt, fault capture) reside in rom_port_arbiter, which must be 120-400 lines of RTL in total.
REQ-035 The block instantiates no ROM; it connects to the ROM through the rom_* ports.

Verification
REQ-036 IF only:
- Stimulus: if_addr=0x00000004, ROM returns 0x26310000 with accessable=1.
- Response: if_ready in the same cycle; in the next cycle if_valid=1, if_data=0x26310000, if_fault=0.
REQ-037 Contention:
- Stimulus: if_req and dm_req held high with STARVE_LIMIT=4.
- Response: DM is granted in cycles 1-4, IF in cycle 5, DM in cycles 6-9, and the pattern repeats; the two ready signals are never high together.
REQ-038 Misaligned DM address:
- Stimulus: dm_addr=0x00000002.
- Response: next cycle dm_valid=1, dm_fault=1, dm_data=0; fault_sticky=1, fault_addr=0x00000002, fault_port=1.
REQ-039 Unmapped IF address and sticky capture:
- Stimulus: if_addr=0x00000010 with accessable=0.
- Response: IF fault is captured; a second fault at 0x00400FFC leaves fault_addr=0x00000010.
- Then: fault_clear together with a fault at 0x00000020 gives fault_addr=0x00000020 and fault_sticky=1.
REQ-040 Reset after accept:
- Stimulus: a DM accept, then reset=1 in the following cycle.
- Response: dm_valid stays 0 and all outputs are 0; after release, starve_cnt starts at 0.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants, payload types and helpers for the ROM port arbiter.
package rom_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ROM_BOOT_BASE = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ROM_PROG_BASE = 32'h0040_0000;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    // One registered response towards a requester.
    typedef struct packed {
        logic              valid;
        logic              fault;
        logic [DATA_W-1:0] data;
    } rom_rsp_t;

    // First-fault capture record.
    typedef struct packed {
        logic              sticky;
        logic              port;
        logic [ADDR_W-1:0] addr;
    } fault_rec_t;

    // An access faults when the word address is misaligned or unmapped.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                        input logic              accessable);
        return (addr[1:0] != 2'b00) || !accessable;
    endfunction

endpackage

// File: rtl/rom_grant_pick.sv
// Combinational winner selection between the IF and DM requesters.
module rom_grant_pick (
    input  logic if_req,
    input  logic dm_req,
    input  logic starve_hit,
    output logic gnt_if,
    output logic gnt_dm
);

    // DM wins ties unless IF has been denied long enough to be forced through.
    always_comb begin
        gnt_if = if_req && (!dm_req || starve_hit);
        gnt_dm = dm_req && !gnt_if;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a combinational ROM: one access per cycle,
// registered responses, IF anti-starvation and first-fault capture.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              if_fault,

    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    output logic              dm_ready,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_data,
    output logic              dm_fault,

    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_accessable,

    input  logic              fault_clear,
    output logic              fault_sticky,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              fault_port
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic              starve_hit;
    logic              gnt_if;
    logic              gnt_dm;
    logic              acc_if;
    logic              acc_dm;
    logic              acc_fault;
    logic [ADDR_W-1:0] acc_addr;
    rom_rsp_t          rsp_next;
    rom_rsp_t          if_rsp_q;
    rom_rsp_t          dm_rsp_q;
    fault_rec_t        flt_q;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    rom_grant_pick u_pick (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_hit (starve_hit),
        .gnt_if     (gnt_if),
        .gnt_dm     (gnt_dm)
    );

    // Accept qualification, ROM address mux and the response for this cycle's accept.
    always_comb begin
        acc_if   = gnt_if && !reset;
        acc_dm   = gnt_dm && !reset;
        acc_addr = '0;
        if (acc_if) begin
            acc_addr = if_addr;
        end else if (acc_dm) begin
            acc_addr = dm_addr;
        end
        acc_fault      = (acc_if || acc_dm) && addr_fault(acc_addr, rom_accessable);
        rsp_next       = '0;
        rsp_next.valid = 1'b1;
        rsp_next.fault = acc_fault;
        rsp_next.data  = acc_fault ? '0 : rom_data;
    end

    assign if_ready = acc_if;
    assign dm_ready = acc_dm;
    assign rom_addr = acc_addr;

    // Response registers: a single-cycle valid pulse per accept, cleared otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rsp_q <= '0;
            dm_rsp_q <= '0;
        end else begin
            if_rsp_q <= acc_if ? rsp_next : '0;
            dm_rsp_q <= acc_dm ? rsp_next : '0;
        end
    end

    // Count consecutive denied IF cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_req && !acc_if) begin
            if (!starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // First-fault capture; a clear in the same cycle as a new fault re-arms and captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            flt_q <= '0;
        end else if (acc_fault && (!flt_q.sticky || fault_clear)) begin
            flt_q.sticky <= 1'b1;
            flt_q.addr   <= acc_addr;
            flt_q.port   <= acc_dm ? PORT_DM : PORT_IF;
        end else if (fault_clear) begin
            flt_q.sticky <= 1'b0;
        end
    end

    assign if_valid     = if_rsp_q.valid;
    assign if_fault     = if_rsp_q.fault;
    assign if_data      = if_rsp_q.data;
    assign dm_valid     = dm_rsp_q.valid;
    assign dm_fault     = dm_rsp_q.fault;
    assign dm_data      = dm_rsp_q.data;
    assign fault_sticky = flt_q.sticky;
    assign fault_addr   = flt_q.addr;
    assign fault_port   = flt_q.port;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed vector table plus randomized traffic
// against a cycle-level reference model.
module tb_rom_port_arbiter;
    import rom_port_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        if_req, dm_req, fault_clear, map_en;
    logic [31:0] if_addr, dm_addr, rom_addr, rom_data, if_data, dm_data, fault_addr;
    logic        if_ready, if_valid, if_fault, dm_ready, dm_valid, dm_fault;
    logic        rom_accessable, fault_sticky, fault_port;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_starve;
    logic        m_gif, m_gdm, m_after_rst;
    logic        m_if_v, m_if_f, m_dm_v, m_dm_f, m_s, m_fp;
    logic [31:0] m_if_d, m_dm_d, m_fa;

    // Bench ROM: 4 KiB mapped at each base, word contents derived from the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h2631_0000 : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic rom_mapped(input logic [31:0] a);
        logic [31:0] ob, op;
        ob = a - ROM_BOOT_BASE;
        op = a - ROM_PROG_BASE;
        return (ob < 32'h1000) || (op < 32'h1000);
    endfunction

    assign rom_data       = rom_word(rom_addr);
    assign rom_accessable = map_en && rom_mapped(rom_addr);

    rom_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ready       (if_ready),
        .if_valid       (if_valid),
        .if_data        (if_data),
        .if_fault       (if_fault),
        .dm_req         (dm_req),
        .dm_addr        (dm_addr),
        .dm_ready       (dm_ready),
        .dm_valid       (dm_valid),
        .dm_data        (dm_data),
        .dm_fault       (dm_fault),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_accessable (rom_accessable),
        .fault_clear    (fault_clear),
        .fault_sticky   (fault_sticky),
        .fault_addr     (fault_addr),
        .fault_port     (fault_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da,
                         input logic fc, input logic me);
        reset = r; if_req = ir; if_addr = ia; dm_req = dr; dm_addr = da;
        fault_clear = fc; map_en = me;
    endtask

    // Combinational checks mid-cycle: who the model says wins this cycle.
    task automatic settle_pre();
        logic [31:0] ea;
        #1;
        m_gif = !reset && if_req && (!dm_req || (m_starve == int'(LIMIT)));
        m_gdm = !reset && dm_req && !m_gif;
        ea = m_gif ? if_addr : (m_gdm ? dm_addr : 32'h0);
        chk("if_ready", 32'(if_ready), 32'(m_gif));
        chk("dm_ready", 32'(dm_ready), 32'(m_gdm));
        chk("ready_exclusive", 32'(if_ready && dm_ready), 32'h0);
        chk("rom_addr", rom_addr, ea);
    endtask

    // Advance the model across the edge, then check registered outputs.
    task automatic clock_post();
        logic fi, fd, anyf;
        fi = m_gif && ((if_addr[1:0] != 2'b00) || !(map_en && rom_mapped(if_addr)));
        fd = m_gdm && ((dm_addr[1:0] != 2'b00) || !(map_en && rom_mapped(dm_addr)));
        if (reset) begin
            m_if_v = 0; m_if_f = 0; m_if_d = 0;
            m_dm_v = 0; m_dm_f = 0; m_dm_d = 0;
            m_s = 0; m_fa = 0; m_fp = 0; m_starve = 0; m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            m_if_v = m_gif; m_if_f = fi; m_if_d = fi ? 32'h0 : rom_word(if_addr);
            m_dm_v = m_gdm; m_dm_f = fd; m_dm_d = fd ? 32'h0 : rom_word(dm_addr);
            anyf = fi || fd;
            if (anyf && (!m_s || fault_clear)) begin
                m_s = 1; m_fa = m_gif ? if_addr : dm_addr; m_fp = m_gdm;
            end else if (fault_clear) begin
                m_s = 0;
            end
            if (if_req && !m_gif) m_starve = (m_starve < int'(LIMIT)) ? m_starve + 1 : m_starve;
            else m_starve = 0;
        end
        @(posedge clk);
        #1;
        chk("if_valid", 32'(if_valid), 32'(m_if_v));
        chk("if_fault", 32'(if_fault), 32'(m_if_f));
        if (m_if_v || m_after_rst) chk("if_data", if_data, m_if_d);
        chk("dm_valid", 32'(dm_valid), 32'(m_dm_v));
        chk("dm_fault", 32'(dm_fault), 32'(m_dm_f));
        if (m_dm_v || m_after_rst) chk("dm_data", dm_data, m_dm_d);
        chk("fault_sticky", 32'(fault_sticky), 32'(m_s));
        chk("fault_addr", fault_addr, m_fa);
        chk("fault_port", 32'(fault_port), 32'(m_fp));
    endtask

    typedef struct {
        logic        r, ir, dr, fc, me;
        logic [31:0] ia, da;
        logic        e_ifr, e_dmr;
        logic [31:0] e_ra;
        logic        e_ifv, e_iff, e_dmv, e_dmf, e_s, e_fp;
        logic [31:0] e_ifd, e_dmd, e_fa;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [31:0] ia, input logic dr,
        input logic [31:0] da, input logic fc, input logic me,
        input logic e_ifr, input logic e_dmr, input logic [31:0] e_ra,
        input logic e_ifv, input logic [31:0] e_ifd, input logic e_iff,
        input logic e_dmv, input logic [31:0] e_dmd, input logic e_dmf,
        input logic e_s, input logic [31:0] e_fa, input logic e_fp);
        vec_t v;
        v.r = r; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.fc = fc; v.me = me;
        v.e_ifr = e_ifr; v.e_dmr = e_dmr; v.e_ra = e_ra;
        v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_iff = e_iff;
        v.e_dmv = e_dmv; v.e_dmd = e_dmd; v.e_dmf = e_dmf;
        v.e_s = e_s; v.e_fa = e_fa; v.e_fp = e_fp;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        case ($urandom_range(0, 3))
            0:       return ROM_BOOT_BASE + off;
            1:       return ROM_PROG_BASE + off;
            2:       return $urandom() & 32'hFFFF_FFFC;
            default: return $urandom();
        endcase
    endfunction

    vec_t tbl[$];

    initial begin
        logic        ir, dr;
        logic [31:0] ia, da;

        m_starve = 0; m_gif = 0; m_gdm = 0; m_after_rst = 0;
        m_if_v = 0; m_if_f = 0; m_if_d = 0; m_dm_v = 0; m_dm_f = 0; m_dm_d = 0;
        m_s = 0; m_fa = 0; m_fp = 0;
        drive(1, 0, 0, 0, 0, 0, 1);

        //             r ir ia            dr da      fc me  ifr dmr ra            ifv ifd            iff dmv dmd            dmf s  fa            fp
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk(1, 1, 32'h4,        1, 32'hC, 0, 1,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 32'h4,        0, 32'h0, 0, 1,  1, 0, 32'h4,        1, 32'h26310000, 0,  0, 32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0, 0, 1,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h2, 0, 1,  0, 1, 32'h2,        0, 32'h0,        0,  1, 32'h0,        1,  1, 32'h2,        1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0, 1, 1,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h2,        1));
        tbl.push_back(mk(0, 1, 32'h10,       0, 32'h0, 0, 0,  1, 0, 32'h10,       1, 32'h0,        1,  0, 32'h0,        0,  1, 32'h10,       0));
        tbl.push_back(mk(0, 1, 32'h400FFC,   0, 32'h0, 0, 0,  1, 0, 32'h400FFC,   1, 32'h0,        1,  0, 32'h0,        0,  1, 32'h10,       0));
        tbl.push_back(mk(0, 1, 32'h20,       0, 32'h0, 1, 0,  1, 0, 32'h20,       1, 32'h0,        1,  0, 32'h0,        0,  1, 32'h20,       0));
        tbl.push_back(mk(0, 1, 32'h400010,   0, 32'h0, 0, 1,  1, 0, 32'h400010,   1, 32'hA5E50010, 0,  0, 32'h0,        0,  1, 32'h20,       0));
        tbl.push_back(mk(0, 1, 32'h8,        0, 32'h0, 0, 1,  1, 0, 32'h8,        1, 32'hA5A50008, 0,  0, 32'h0,        0,  1, 32'h20,       0));
        tbl.push_back(mk(0, 1, 32'h8,        1, 32'hC, 0, 1,  0, 1, 32'hC,        0, 32'h0,        0,  1, 32'hA5A5000C, 0,  1, 32'h20,       0));
        tbl.push_back(mk(0, 1, 32'h8,        1, 32'hC, 0, 1,  0, 1, 32'hC,        0, 32'h0,        0,  1, 32'hA5A5000C, 0,  1, 32'h20,       0));
        tbl.push_back(mk(1, 1, 32'h8,        1, 32'hC, 0, 1,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0,  0, 32'h0,        0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 1, 32'h8,    1, 32'hC, 0, 1,  0, 1, 32'hC,        0, 32'h0,        0,  1, 32'hA5A5000C, 0,  0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 32'h8,        1, 32'hC, 0, 1,  1, 0, 32'h8,        1, 32'hA5A50008, 0,  0, 32'h0,        0,  0, 32'h0,        0));
        tbl.push_back(mk(0, 1, 32'h8,        1, 32'hC, 0, 1,  0, 1, 32'hC,        0, 32'h0,        0,  1, 32'hA5A5000C, 0,  0, 32'h0,        0));

        // Directed vectors
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].da, tbl[i].fc, tbl[i].me);
            settle_pre();
            chk($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(tbl[i].e_ifr));
            chk($sformatf("v%0d_dm_ready", i), 32'(dm_ready), 32'(tbl[i].e_dmr));
            chk($sformatf("v%0d_rom_addr", i), rom_addr, tbl[i].e_ra);
            clock_post();
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            chk($sformatf("v%0d_if_fault", i), 32'(if_fault), 32'(tbl[i].e_iff));
            if (tbl[i].e_ifv) chk($sformatf("v%0d_if_data", i), if_data, tbl[i].e_ifd);
            chk($sformatf("v%0d_dm_valid", i), 32'(dm_valid), 32'(tbl[i].e_dmv));
            chk($sformatf("v%0d_dm_fault", i), 32'(dm_fault), 32'(tbl[i].e_dmf));
            if (tbl[i].e_dmv) chk($sformatf("v%0d_dm_data", i), dm_data, tbl[i].e_dmd);
            chk($sformatf("v%0d_fault_sticky", i), 32'(fault_sticky), 32'(tbl[i].e_s));
            chk($sformatf("v%0d_fault_addr", i), fault_addr, tbl[i].e_fa);
            chk($sformatf("v%0d_fault_port", i), 32'(fault_port), 32'(tbl[i].e_fp));
        end

        // Randomized traffic; a denied requester holds its request and address.
        ir = 0; dr = 0; ia = 0; da = 0;
        for (int c = 0; c < 2000; c++) begin
            logic r;
            r = ($urandom_range(0, 63) == 0);
            if (!(ir && !m_gif && !reset)) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = rand_addr();
            end
            if (!(dr && !m_gdm && !reset)) begin
                dr = ($urandom_range(0, 2) != 0);
                da = rand_addr();
            end
            drive(r, ir, ia, dr, da, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
            settle_pre();
            clock_post();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
